ring_osc_trim_cal: RTL

RING_OSC_TRIM_CAL -- requirements
Module: ring_osc_trim_cal

---
 rtl/ring_osc_cal_pkg.sv | 28 ++
 rtl/osc_edge_counter.sv | 45 ++++
 rtl/ring_osc_trim_cal.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ring_osc_cal_pkg.sv
// Shared definitions for the ring-oscillator trim calibration block:
// FSM states, trim geometry and the code-to-trim thermometer mapping.
package ring_osc_cal_pkg;

  localparam int unsigned NUM_STAGES = 13;
  localparam int unsigned MAX_CODE   = 26;

  typedef enum logic [2:0] {
    IDLE,
    ORST,
    SETTLE,
    MEAS,
    EVAL,
    FIN
  } cal_state_e;

  // Primary trims (bits 0..12) fill first, then secondary trims (13..25).
  function automatic logic [2*NUM_STAGES-1:0] code_to_trim(input logic [4:0] code);
    logic [2*NUM_STAGES-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (i < 32'(code)) t[i] = 1'b1;
      if (i + NUM_STAGES < 32'(code)) t[i+NUM_STAGES] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/osc_edge_counter.sv
// Synchronizes the divided oscillator toggle into clk and counts every
// edge (rise or fall) while enabled, saturating at all-ones.
module osc_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic             osc_tgl,
  output logic [CNT_W-1:0] count
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_det;

  assign edge_det = sync2_q ^ prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && edge_det && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= osc_tgl;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/ring_osc_trim_cal.sv
// Ring-oscillator trim calibration: steps the trim code upward from 0 until
// the measured edge count per window falls to or below the target.
module ring_osc_trim_cal
  import ring_osc_cal_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             osc_tgl,
  input  logic [CNT_W-1:0] window_len,
  input  logic [CNT_W-1:0] target,
  output logic             osc_reset,
  output logic [25:0]      trim,
  output logic             busy,
  output logic             done,
  output logic [4:0]       cal_code,
  output logic [CNT_W-1:0] meas_count,
  output logic             err_slow,
  output logic             err_fast
);

  cal_state_e       state_q, state_d;
  logic [31:0]      tmr_q, tmr_d;
  logic [CNT_W-1:0] win_q, win_d, tgt_q, tgt_d, meas_q, meas_d;
  logic [25:0]      trim_q, trim_d;
  logic [4:0]       code_q, code_d;
  logic             osc_reset_q, osc_reset_d, busy_q, busy_d, done_q, done_d;
  logic             es_q, es_d, ef_q, ef_d;
  logic [CNT_W-1:0] edge_cnt;

  osc_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (state_q == SETTLE),
    .en      (state_q == MEAS),
    .osc_tgl (osc_tgl),
    .count   (edge_cnt)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    win_d       = win_q;
    tgt_d       = tgt_q;
    meas_d      = meas_q;
    trim_d      = trim_q;
    code_d      = code_q;
    osc_reset_d = osc_reset_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    es_d        = es_q;
    ef_d        = ef_q;
    case (state_q)
      IDLE: if (start) begin
        win_d       = (window_len == '0) ? CNT_W'(1) : window_len;
        tgt_d       = target;
        code_d      = '0;
        trim_d      = code_to_trim(5'd0);
        es_d        = 1'b0;
        ef_d        = 1'b0;
        busy_d      = 1'b1;
        osc_reset_d = 1'b1;
        tmr_d       = '0;
        state_d     = ORST;
      end
      ORST: begin
        if (tmr_q == 32'(RST_CYCLES - 1)) begin
          tmr_d       = '0;
          osc_reset_d = 1'b0;
          state_d     = SETTLE;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      SETTLE: begin
        if (tmr_q == 32'(SETTLE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = MEAS;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      MEAS: begin
        if (tmr_q == 32'(win_q) - 32'd1) begin
          tmr_d   = '0;
          state_d = EVAL;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      EVAL: begin
        meas_d = edge_cnt;
        if (edge_cnt <= tgt_q) begin
          es_d    = (code_q == '0);
          done_d  = 1'b1;
          state_d = FIN;
        end else if (code_q == 5'(MAX_CODE)) begin
          ef_d    = 1'b1;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          code_d  = code_q + 5'd1;
          trim_d  = code_to_trim(code_q + 5'd1);
          state_d = SETTLE;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the active state computed, freezing code/trim.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      tmr_d       = '0;
      osc_reset_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      code_d      = code_q;
      trim_d      = trim_q;
      meas_d      = meas_q;
      es_d        = es_q;
      ef_d        = ef_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      win_q       <= '0;
      tgt_q       <= '0;
      meas_q      <= '0;
      trim_q      <= '0;
      code_q      <= '0;
      osc_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      es_q        <= 1'b0;
      ef_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      win_q       <= win_d;
      tgt_q       <= tgt_d;
      meas_q      <= meas_d;
      trim_q      <= trim_d;
      code_q      <= code_d;
      osc_reset_q <= osc_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      es_q        <= es_d;
      ef_q        <= ef_d;
    end
  end

  assign osc_reset  = osc_reset_q;
  assign trim       = trim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cal_code   = code_q;
  assign meas_count = meas_q;
  assign err_slow   = es_q;
  assign err_fast   = ef_q;

endmodule
